// File: rtl/lbp_result_checker.sv
// rtl/lbp_result_checker.sv - captures result writes, sweeps them against an expected image, logs mismatches
module lbp_result_checker #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 14,
   parameter int MAX_LOG = 10,
   parameter int STRICT  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              finish,
   output logic [ADDR_W-1:0] exp_addr,
   input  logic [DATA_W-1:0] exp_data,
   output logic              err_valid,
   output logic [ADDR_W-1:0] err_addr,
   output logic [DATA_W-1:0] err_got,
   output logic [DATA_W-1:0] err_exp,
   output logic [ADDR_W:0]   err_count,
   output logic              dup_wr,
   output logic              late_wr,
   output logic              done,
   output logic              pass
);
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {CAPTURE, SWEEP, FLUSH, DONE_ST} state_t;
   state_t state;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  written;

   // Pipeline stage aligning mem[k] and its written flag with exp_data for address k
   logic [DATA_W-1:0] mem_q;
   logic              wr_q;
   logic [ADDR_W-1:0] cmp_addr;
   logic              cmp_valid;

   logic [DATA_W-1:0] got;
   logic              mism;
   logic              log_en;
   logic              late_nxt;
   logic              done_nxt;
   logic [ADDR_W:0]   cnt_nxt;

   always_comb begin
      got      = wr_q ? mem_q : '0;
      mism     = cmp_valid && ((got != exp_data) || (STRICT != 0 && !wr_q));
      log_en   = mism && (int'(err_count) < MAX_LOG);
      cnt_nxt  = err_count + (ADDR_W+1)'(mism);
      late_nxt = late_wr | (wr_valid && state != CAPTURE);
      done_nxt = (state == FLUSH) || (state == DONE_ST);
   end

   // Array contents survive reset; stale cells are masked by the written flags
   always_ff @(posedge clk) begin
      if (reset && state == CAPTURE && wr_valid)
         mem[wr_addr] <= wr_data;
      mem_q <= mem[exp_addr];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= CAPTURE;
         exp_addr  <= '0;
         err_valid <= 1'b0;
         err_addr  <= '0;
         err_got   <= '0;
         err_exp   <= '0;
         err_count <= '0;
         dup_wr    <= 1'b0;
         late_wr   <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         written   <= '0;
         wr_q      <= 1'b0;
         cmp_addr  <= '0;
         cmp_valid <= 1'b0;
      end else begin
         err_valid <= log_en;
         if (log_en) begin
            err_addr <= cmp_addr;
            err_got  <= got;
            err_exp  <= exp_data;
         end
         err_count <= cnt_nxt;
         late_wr   <= late_nxt;
         done      <= done_nxt;
         pass      <= done_nxt && (cnt_nxt == '0) && !late_nxt;
         wr_q      <= written[exp_addr];
         cmp_addr  <= exp_addr;
         cmp_valid <= (state == SWEEP);
         case (state)
            CAPTURE: begin
               if (wr_valid) begin
                  written[wr_addr] <= 1'b1;
                  if (written[wr_addr])
                     dup_wr <= 1'b1;
               end
               if (finish) begin
                  state    <= SWEEP;
                  exp_addr <= '0;
               end
            end
            SWEEP: begin
               if (exp_addr == '1)
                  state <= FLUSH;
               else
                  exp_addr <= exp_addr + ADDR_W'(1);
            end
            FLUSH:   state <= DONE_ST;
            default: ;
         endcase
      end
   end
endmodule
